// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU decode-and-issue stage: ALUControl codes, MIPS
// opcode/funct values, FSM state encoding and the ID/EX control record.
package alu_pkg;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t AluAnd  = 5'd0;
  localparam alu_op_t AluAdd  = 5'd1;
  localparam alu_op_t AluSub  = 5'd2;
  localparam alu_op_t AluMul  = 5'd3;
  localparam alu_op_t AluOr   = 5'd4;
  localparam alu_op_t AluNor  = 5'd5;
  localparam alu_op_t AluXor  = 5'd6;
  localparam alu_op_t AluSll  = 5'd7;
  localparam alu_op_t AluSrl  = 5'd8;
  localparam alu_op_t AluSlt  = 5'd9;
  localparam alu_op_t AluBgez = 5'd10;
  localparam alu_op_t AluBgtz = 5'd11;
  localparam alu_op_t AluBlez = 5'd12;
  localparam alu_op_t AluBltz = 5'd13;
  localparam alu_op_t AluBne  = 5'd14;
  localparam alu_op_t AluBeq  = 5'd15;
  localparam alu_op_t AluJ    = 5'd16;

  localparam logic [5:0] OpRtype    = 6'h00;
  localparam logic [5:0] OpRegimm   = 6'h01;
  localparam logic [5:0] OpJ        = 6'h02;
  localparam logic [5:0] OpJal      = 6'h03;
  localparam logic [5:0] OpBeq      = 6'h04;
  localparam logic [5:0] OpBne      = 6'h05;
  localparam logic [5:0] OpBlez     = 6'h06;
  localparam logic [5:0] OpBgtz     = 6'h07;
  localparam logic [5:0] OpAddi     = 6'h08;
  localparam logic [5:0] OpAddiu    = 6'h09;
  localparam logic [5:0] OpSlti     = 6'h0A;
  localparam logic [5:0] OpAndi     = 6'h0C;
  localparam logic [5:0] OpOri      = 6'h0D;
  localparam logic [5:0] OpXori     = 6'h0E;
  localparam logic [5:0] OpSpecial2 = 6'h1C;
  localparam logic [5:0] OpLb       = 6'h20;
  localparam logic [5:0] OpLw       = 6'h23;
  localparam logic [5:0] OpSb       = 6'h28;
  localparam logic [5:0] OpSw       = 6'h2B;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnMul  = 6'h02;

  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StBusy = 1'b1;

  localparam int unsigned MulLatMin = 1;
  localparam int unsigned MulLatMax = 8;
  localparam int unsigned CntW      = 3;

  typedef struct packed {
    alu_op_t op;
    logic    src_b;
    logic    shamt_sel;
    logic    imm_zext;
    logic    illegal;
  } dec_t;

  typedef struct packed {
    logic    valid;
    alu_op_t op;
    logic    src_b;
    logic    shamt_sel;
    logic    imm_zext;
    logic    illegal;
  } idex_t;

  localparam idex_t Bubble = '0;

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// Handshake and control bundle between IF/ID, the issue stage and EX.
interface alu_ctrl_issue_if;
  import alu_pkg::*;

  logic [31:0] Instr;
  logic        InValid;
  logic        InReady;
  logic        Stall;
  logic        Flush;
  logic        OutValid;
  alu_op_t     ALUControl;
  logic        ALUSrcB;
  logic        ShamtSel;
  logic        ImmZeroExt;
  logic        Illegal;

  modport master (
    output Instr, InValid, Stall, Flush,
    input  InReady, OutValid, ALUControl, ALUSrcB, ShamtSel, ImmZeroExt, Illegal
  );

  modport slave (
    input  Instr, InValid, Stall, Flush,
    output InReady, OutValid, ALUControl, ALUSrcB, ShamtSel, ImmZeroExt, Illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction decoder producing ALUControl and operand selects.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];

  // rs, rd, shamt and immediate go straight to the datapath
  logic unused_instr;
  assign unused_instr = ^{instr[25:21], instr[15:6]};

  always_comb begin
    dec = '0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAnd:         dec.op = AluAnd;
          FnAdd, FnAddu: dec.op = AluAdd;
          FnSub:         dec.op = AluSub;
          FnOr:          dec.op = AluOr;
          FnNor:         dec.op = AluNor;
          FnXor:         dec.op = AluXor;
          FnSlt:         dec.op = AluSlt;
          FnSll: begin dec.op = AluSll; dec.shamt_sel = 1'b1; end
          FnSrl: begin dec.op = AluSrl; dec.shamt_sel = 1'b1; end
          FnJr:          dec.op = AluJ;
          default:       dec.illegal = 1'b1;
        endcase
      end
      OpSpecial2: begin
        if (funct == FnMul) dec.op = AluMul;
        else                dec.illegal = 1'b1;
      end
      OpAddi, OpAddiu, OpLw, OpSw, OpLb, OpSb: begin
        dec.op = AluAdd; dec.src_b = 1'b1;
      end
      OpSlti: begin dec.op = AluSlt; dec.src_b = 1'b1; end
      OpAndi: begin dec.op = AluAnd; dec.src_b = 1'b1; dec.imm_zext = 1'b1; end
      OpOri:  begin dec.op = AluOr;  dec.src_b = 1'b1; dec.imm_zext = 1'b1; end
      OpXori: begin dec.op = AluXor; dec.src_b = 1'b1; dec.imm_zext = 1'b1; end
      OpBeq:  dec.op = AluBeq;
      OpBne:  dec.op = AluBne;
      OpBlez: dec.op = AluBlez;
      OpBgtz: dec.op = AluBgtz;
      OpRegimm: begin
        case (rt)
          5'd1:    dec.op = AluBgez;
          5'd0:    dec.op = AluBltz;
          default: dec.illegal = 1'b1;
        endcase
      end
      OpJ, OpJal: dec.op = AluJ;
      default:    dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode-and-issue stage: ID/EX control register, hazard hold, flush and mul occupancy FSM.
// Optional macro ALU_ILLEGAL_TRAP_EN turns unsupported encodings into an Illegal bubble.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  alu_ctrl_issue_if.slave  bus
);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  idex_t           idex_q, idex_d;
  idex_t           dec_load;
  dec_t            dec;
  logic            accept;
  logic            is_mul;

  alu_ctrl_decode u_decode (
    .instr (bus.Instr),
    .dec   (dec)
  );

  assign bus.InReady = (state_q == StIdle) & ~bus.Stall;
  assign accept      = bus.InValid & bus.InReady;
  assign is_mul      = ~dec.illegal & (dec.op == AluMul);

  always_comb begin
    dec_load = Bubble;
`ifdef ALU_ILLEGAL_TRAP_EN
    if (dec.illegal) begin
      dec_load.illegal = 1'b1;
    end else begin
      dec_load.valid     = 1'b1;
      dec_load.op        = dec.op;
      dec_load.src_b     = dec.src_b;
      dec_load.shamt_sel = dec.shamt_sel;
      dec_load.imm_zext  = dec.imm_zext;
    end
`else
    // Unsupported encodings fall through as the decoder's default And, reg-reg
    dec_load.valid     = 1'b1;
    dec_load.op        = dec.op;
    dec_load.src_b     = dec.src_b;
    dec_load.shamt_sel = dec.shamt_sel;
    dec_load.imm_zext  = dec.imm_zext;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idex_d  = idex_q;
    if (bus.Flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      idex_d  = Bubble;
    end else if (state_q == StBusy) begin
      // Leave BUSY on the edge where the count has reached 1
      if (cnt_q == CntW'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (bus.Stall) begin
      idex_d = idex_q;
    end else if (accept) begin
      idex_d = dec_load;
      if (is_mul && (MUL_LAT > 1)) begin
        state_d = StBusy;
        cnt_d   = CntW'(MUL_LAT - 1);
      end
    end else begin
      idex_d = Bubble;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idex_q  <= Bubble;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idex_q  <= idex_d;
    end
  end

  assign bus.OutValid   = idex_q.valid;
  assign bus.ALUControl = idex_q.op;
  assign bus.ALUSrcB    = idex_q.src_b;
  assign bus.ShamtSel   = idex_q.shamt_sel;
  assign bus.ImmZeroExt = idex_q.imm_zext;
  assign bus.Illegal    = idex_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue: decode table plus mul occupancy, flush, stall and reset.
module tb_alu_ctrl_issue;
  import alu_pkg::*;

  logic Clk;
  logic Rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_ctrl_issue_if bus ();

  alu_ctrl_issue #(.MUL_LAT(3)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // {OutValid, ALUControl, ALUSrcB, ShamtSel, ImmZeroExt, Illegal}
  logic [9:0] outs;
  assign outs = {bus.OutValid, bus.ALUControl, bus.ALUSrcB, bus.ShamtSel, bus.ImmZeroExt,
                 bus.Illegal};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [9:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] ex(input logic v, input logic [4:0] op, input logic sb,
                                    input logic sh, input logic ze, input logic il);
    return {v, op, sb, sh, ze, il};
  endfunction

  function automatic logic [9:0] ex_illegal();
`ifdef ALU_ILLEGAL_TRAP_EN
    return ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    return ex(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic check_ready(input string name, input logic exp);
    check(name, {9'd0, bus.InReady}, {9'd0, exp});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vecs.push_back('{"and",    32'h00430824, ex(1, 5'd0,  0, 0, 0, 0)});
    vecs.push_back('{"sub",    32'h00430822, ex(1, 5'd2,  0, 0, 0, 0)});
    vecs.push_back('{"nor",    32'h00430827, ex(1, 5'd5,  0, 0, 0, 0)});
    vecs.push_back('{"xor",    32'h00430826, ex(1, 5'd6,  0, 0, 0, 0)});
    vecs.push_back('{"slt",    32'h0043082A, ex(1, 5'd9,  0, 0, 0, 0)});
    vecs.push_back('{"sll",    32'h00020900, ex(1, 5'd7,  0, 1, 0, 0)});
    vecs.push_back('{"srl",    32'h00020902, ex(1, 5'd8,  0, 1, 0, 0)});
    vecs.push_back('{"jr",     32'h03E00008, ex(1, 5'd16, 0, 0, 0, 0)});
    vecs.push_back('{"ori",    32'h344100FF, ex(1, 5'd4,  1, 0, 1, 0)});
    vecs.push_back('{"andi",   32'h304100FF, ex(1, 5'd0,  1, 0, 1, 0)});
    vecs.push_back('{"xori",   32'h384100FF, ex(1, 5'd6,  1, 0, 1, 0)});
    vecs.push_back('{"addi",   32'h20410005, ex(1, 5'd1,  1, 0, 0, 0)});
    vecs.push_back('{"lw",     32'h8C410004, ex(1, 5'd1,  1, 0, 0, 0)});
    vecs.push_back('{"sb",     32'hA0410000, ex(1, 5'd1,  1, 0, 0, 0)});
    vecs.push_back('{"slti",   32'h28410001, ex(1, 5'd9,  1, 0, 0, 0)});
    vecs.push_back('{"beq",    32'h10410003, ex(1, 5'd15, 0, 0, 0, 0)});
    vecs.push_back('{"bne",    32'h14410003, ex(1, 5'd14, 0, 0, 0, 0)});
    vecs.push_back('{"blez",   32'h18400003, ex(1, 5'd12, 0, 0, 0, 0)});
    vecs.push_back('{"bgtz",   32'h1C400003, ex(1, 5'd11, 0, 0, 0, 0)});
    vecs.push_back('{"bgez",   32'h04410003, ex(1, 5'd10, 0, 0, 0, 0)});
    vecs.push_back('{"bltz",   32'h04400003, ex(1, 5'd13, 0, 0, 0, 0)});
    vecs.push_back('{"j",      32'h08000010, ex(1, 5'd16, 0, 0, 0, 0)});
    vecs.push_back('{"op3f",   32'hFC000000, ex_illegal()});
    vecs.push_back('{"ori2",   32'h344100FF, ex(1, 5'd4,  1, 0, 1, 0)});
    vecs.push_back('{"fn3f",   32'h0000003F, ex_illegal()});

    bus.Instr   = 32'h00430820;
    bus.InValid = 1'b1;
    bus.Stall   = 1'b0;
    bus.Flush   = 1'b0;
    Rst_n       = 1'b1;
    #2 Rst_n    = 1'b0;
    tick();
    tick();
    check("reset_outs", outs, 10'd0);

    Rst_n = 1'b1;
    #1;
    check_ready("ready_after_reset", 1'b1);
    tick();
    check("add", outs, ex(1, 5'd1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      bus.Instr   = vecs[i].instr;
      bus.InValid = 1'b1;
      tick();
      check(vecs[i].name, outs, vecs[i].exp);
    end

    // mul occupancy: held for 3 edges, InReady low 2 cycles, then sub issues
    bus.Instr = 32'h70430802;
    tick();
    check("mul_e0", outs, ex(1, 5'd3, 0, 0, 0, 0));
    check_ready("mul_rdy0", 1'b0);
    bus.Instr = 32'h00430822;
    tick();
    check("mul_e1", outs, ex(1, 5'd3, 0, 0, 0, 0));
    check_ready("mul_rdy1", 1'b0);
    tick();
    check("mul_e2", outs, ex(1, 5'd3, 0, 0, 0, 0));
    check_ready("mul_rdy2", 1'b1);
    tick();
    check("sub_after_mul", outs, ex(1, 5'd2, 0, 0, 0, 0));

    // bubble when nothing is offered
    bus.InValid = 1'b0;
    tick();
    check("bubble", outs, 10'd0);

    // Flush with Stall during BUSY: bubble, IDLE, presented instruction dropped
    bus.Instr   = 32'h70430802;
    bus.InValid = 1'b1;
    tick();
    check("mul_flush_e0", outs, ex(1, 5'd3, 0, 0, 0, 0));
    bus.Instr = 32'h00430822;
    bus.Stall = 1'b1;
    bus.Flush = 1'b1;
    tick();
    check("flush_bubble", outs, 10'd0);
    bus.Stall   = 1'b0;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    #1;
    check_ready("flush_ready", 1'b1);
    tick();
    check("flush_idle_bubble", outs, 10'd0);

    // jal then Stall for 2 cycles holds j
    bus.Instr   = 32'h0C000010;
    bus.InValid = 1'b1;
    tick();
    check("jal", outs, ex(1, 5'd16, 0, 0, 0, 0));
    bus.Instr = 32'h00430820;
    bus.Stall = 1'b1;
    #1;
    check_ready("stall_ready", 1'b0);
    tick();
    check("stall_hold1", outs, ex(1, 5'd16, 0, 0, 0, 0));
    tick();
    check("stall_hold2", outs, ex(1, 5'd16, 0, 0, 0, 0));
    bus.Stall = 1'b0;
    tick();
    check("add_after_stall", outs, ex(1, 5'd1, 0, 0, 0, 0));

    // asynchronous reset mid-BUSY, checked before any clock edge
    bus.Instr = 32'h70430802;
    tick();
    check("mul_rst_e0", outs, ex(1, 5'd3, 0, 0, 0, 0));
    bus.InValid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs, 10'd0);
    check_ready("async_reset_ready", 1'b1);
    #1 Rst_n = 1'b1;
    tick();
    check("post_reset_bubble", outs, 10'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
